// File: rtl/fetch_req_queue_if.sv
// Fetch-request handshake bundle: multi-lane enqueue side towards the queue,
// single-request valid/ready dequeue side towards the ICache.
interface fetch_req_queue_if #(
  parameter int unsigned ENQ_W = 1,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CUT_W = 2
);
  logic [ENQ_W-1:0]       in_valid;
  logic [ENQ_W*PC_W-1:0]  in_pc;
  logic [ENQ_W*CUT_W-1:0] in_cut;
  logic                   in_ready;
  logic                   out_valid;
  logic [PC_W-1:0]        out_pc;
  logic [CUT_W-1:0]       out_cut;
  logic                   out_ready;

  // Requester / consumer side
  modport master (
    output in_valid, in_pc, in_cut, out_ready,
    input  in_ready, out_valid, out_pc, out_cut
  );

  // Queue side
  modport slave (
    input  in_valid, in_pc, in_cut, out_ready,
    output in_ready, out_valid, out_pc, out_cut
  );
endinterface

// File: rtl/fetch_req_queue.sv
// Fetch-request queue between PC/branch-predict and the ICache: a DEPTH-entry
// ring feeding a registered output slot, with multi-lane enqueue and optional bypass.
module fetch_req_queue #(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned CUT_W        = 2,
  parameter int unsigned ENQ_W        = 1,
  parameter bit          BYPASS       = 1'b1,
  parameter int unsigned AFULL_THRESH = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  fetch_req_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    almost_full,
  output logic                    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [CUT_W-1:0] cut;
  } req_t;

  req_t              ring_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              out_valid_q;
  req_t              out_q;

  req_t              lane_req  [ENQ_W];
  logic [PTR_W-1:0]  lane_widx [ENQ_W];
  logic [ENQ_W-1:0]  lane_acc;
  logic [ENQ_W-1:0]  lane_push;
  logic [CNT_W-1:0]  push_cnt;
  logic              can_enq;
  logic              out_valid_c;
  logic              fire;
  logic              slot_load;
  logic              pop;
  logic              byp;

  // Unpack the flat lane buses into per-lane requests
  always_comb begin
    for (int i = 0; i < ENQ_W; i++) begin
      lane_req[i].pc  = bus.in_pc[i*PC_W +: PC_W];
      lane_req[i].cut = bus.in_cut[i*CUT_W +: CUT_W];
    end
  end

  // Room check uses the registered count only, so out_ready never reaches in_ready
  assign can_enq = !flush && !stall && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_W));

  // A lane is taken only if every older lane is valid too
  always_comb begin
    logic run;
    run      = can_enq;
    lane_acc = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      run         = run && bus.in_valid[i];
      lane_acc[i] = run;
    end
  end

  assign out_valid_c = out_valid_q && !stall;
  assign fire        = out_valid_c && bus.out_ready;
  assign slot_load   = (fire || !out_valid_q) && !stall && !flush;
  assign pop         = slot_load && (count_q != '0);
  assign byp         = BYPASS && slot_load && (count_q == '0) && lane_acc[0];

  // Ring write slots: lanes that skip the ring (bypass) do not consume a slot
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      lane_push[i] = lane_acc[i] && !(byp && (i == 0));
      lane_widx[i] = tail_q + PTR_W'(push_cnt);
      if (lane_push[i]) push_cnt = push_cnt + CNT_W'(1);
    end
  end

  // Pointers, count and output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      tail_q  <= tail_q + PTR_W'(push_cnt);
      head_q  <= head_q + PTR_W'(pop);
      count_q <= count_q + push_cnt - CNT_W'(pop);
      if (slot_load) begin
        out_valid_q <= pop || byp;
        if (pop) begin
          out_q <= ring_q[head_q];
        end else if (byp) begin
          out_q <= lane_req[0];
        end
      end
    end
  end

  // Ring payload storage; not reset, validity is tracked by count/head/tail
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (lane_push[i]) ring_q[lane_widx[i]] <= lane_req[i];
    end
  end

  assign bus.in_ready  = can_enq;
  assign bus.out_valid = out_valid_c;
  assign bus.out_pc    = out_q.pc;
  assign bus.out_cut   = out_q.cut;
  assign occupancy     = count_q;
  assign almost_full   = count_q >= CNT_W'(AFULL_THRESH);
  assign empty         = (count_q == '0) && !out_valid_c;

endmodule

// File: tb/tb_fetch_req_queue.sv
// Scoreboard bench for fetch_req_queue: two configurations driven from shared
// stimulus (lane 0 only for the single-lane one), checked against a queue model.
module tb_fetch_req_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  cut;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [1:0]  v;
  logic [31:0] pc0, pc1;
  logic [1:0]  cut0, cut1;
  logic        ordy;

  logic [5:0]  occ0;
  logic [3:0]  occ1;
  logic        af0, af1, emp0, emp1;

  fetch_req_queue_if #(.ENQ_W(2), .PC_W(32), .CUT_W(2)) bus0 ();
  fetch_req_queue_if #(.ENQ_W(1), .PC_W(32), .CUT_W(2)) bus1 ();

  assign bus0.in_valid  = v;
  assign bus0.in_pc     = {pc1, pc0};
  assign bus0.in_cut    = {cut1, cut0};
  assign bus0.out_ready = ordy;
  assign bus1.in_valid  = v[0];
  assign bus1.in_pc     = pc0;
  assign bus1.in_cut    = cut0;
  assign bus1.out_ready = ordy;

  fetch_req_queue #(.DEPTH(32), .PC_W(32), .CUT_W(2), .ENQ_W(2), .BYPASS(1'b1), .AFULL_THRESH(28)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus0),
    .occupancy(occ0), .almost_full(af0), .empty(emp0));

  fetch_req_queue #(.DEPTH(8), .PC_W(32), .CUT_W(2), .ENQ_W(1), .BYPASS(1'b0), .AFULL_THRESH(6)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus1),
    .occupancy(occ1), .almost_full(af1), .empty(emp1));

  always #5 clk = ~clk;

  // Model: ring occupancy + slot flag per instance; contents live in exp0/exp1 in FIFO order
  int   mcnt  [2] = '{0, 0};
  bit   mslot [2] = '{0, 0};
  req_t exp0 [$];
  req_t exp1 [$];
  bit   e_ready [2] = '{0, 0};
  bit   e_valid [2] = '{0, 0};
  bit   e_empty [2] = '{1, 1};
  bit   e_af    [2] = '{0, 0};
  int   e_occ   [2] = '{0, 0};

  int checks = 0;
  int failures = 0;
  bit fin_req = 0;

  function automatic int dep(input int d);   return (d == 0) ? 32 : 8; endfunction
  function automatic int thr(input int d);   return (d == 0) ? 28 : 6;  endfunction
  function automatic int lanes(input int d); return (d == 0) ? 2 : 1;   endfunction
  function automatic bit bypass(input int d); return d == 0; endfunction
  function automatic int qsize(input int d); return (d == 0) ? exp0.size() : exp1.size(); endfunction

  function automatic void push_exp(input int d, input req_t r);
    if (d == 0) exp0.push_back(r); else exp1.push_back(r);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d]  = 0;
      mslot[d] = 0;
    end
    exp0.delete();
    exp1.delete();
  endtask

  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      e_ready[d] = !flush && !stall && ((dep(d) - mcnt[d]) >= lanes(d));
      e_valid[d] = mslot[d] && !stall;
      e_occ[d]   = mcnt[d];
      e_af[d]    = mcnt[d] >= thr(d);
      e_empty[d] = (mcnt[d] == 0) && !e_valid[d];
    end
  endtask

  task automatic model_step();
    if (flush) begin
      model_reset();
    end else if (!stall) begin
      for (int d = 0; d < 2; d++) begin
        bit a0, a1, fire, load, pop, byp;
        a0   = e_ready[d] && v[0];
        a1   = (lanes(d) == 2) && a0 && v[1];
        fire = e_valid[d] && ordy;
        load = fire || !mslot[d];
        pop  = load && (mcnt[d] > 0);
        byp  = load && (mcnt[d] == 0) && bypass(d) && a0;
        if (a0) push_exp(d, '{pc: pc0, cut: cut0});
        if (a1) push_exp(d, '{pc: pc1, cut: cut1});
        mcnt[d] = mcnt[d] + int'(a0) + int'(a1) - int'(byp) - int'(pop);
        if (load) mslot[d] = pop || byp;
      end
    end
  endtask

  task automatic check(input int d, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL dut%0d %s: got %0h required %0h (t=%0t)", d, nm, act, req, $time);
    end
  endtask

  task automatic chk_dut(input int d, input logic rdy, input logic vld, input logic [31:0] opc,
                         input logic [1:0] ocut, input logic [63:0] occ, input logic af, input logic emp);
    req_t f;
    check(d, "in_ready",    64'(rdy), 64'(e_ready[d]));
    check(d, "out_valid",   64'(vld), 64'(e_valid[d]));
    check(d, "occupancy",   occ,      64'(e_occ[d]));
    check(d, "almost_full", 64'(af),  64'(e_af[d]));
    check(d, "empty",       64'(emp), 64'(e_empty[d]));
    if (vld === 1'b1) begin
      check(d, "out_pending", 64'(qsize(d) != 0), 64'(1));
      if (qsize(d) != 0) begin
        f = (d == 0) ? exp0[0] : exp1[0];
        check(d, "out_pc",  64'(opc),  64'(f.pc));
        check(d, "out_cut", 64'(ocut), 64'(f.cut));
        if (ordy && !flush) begin
          if (d == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
        end
      end
    end
  endtask

  // Monitor: samples mid-cycle, compares against the model, retires requests on handshakes
  initial begin : monitor
    bit fin_seen;
    fin_seen = 0;
    forever begin
      @(negedge clk);
      #2;
      chk_dut(0, bus0.in_ready, bus0.out_valid, bus0.out_pc, bus0.out_cut, 64'(occ0), af0, emp0);
      chk_dut(1, bus1.in_ready, bus1.out_valid, bus1.out_pc, bus1.out_cut, 64'(occ1), af1, emp1);
      if (fin_req && !fin_seen) begin
        fin_seen = 1;
        check(0, "all_emerged", 64'(exp0.size()), 64'(0));
        check(1, "all_emerged", 64'(exp1.size()), 64'(0));
      end
    end
  end

  task automatic cyc(input logic r, input logic st, input logic fl, input logic [1:0] vv,
                     input logic rd, input logic [31:0] p0, input logic [1:0] c0);
    @(negedge clk);
    rst   = r;
    stall = st;
    flush = fl;
    v     = vv;
    ordy  = rd;
    pc0   = p0;
    cut0  = c0;
    pc1   = $urandom;
    cut1  = 2'($urandom);
    if (r) model_reset();
    model_eval();
    @(posedge clk);
    if (!r) model_step();
  endtask

  initial begin : stim
    rst = 1'b1; stall = 1'b0; flush = 1'b0; v = '0; ordy = 1'b0;
    pc0 = '0; pc1 = '0; cut0 = '0; cut1 = '0;
    repeat (3) cyc(1, 0, 0, 2'b00, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 2'b00, 0, 0, 0);

    // single request with ready high: bypass vs ring latency
    cyc(0, 0, 0, 2'b01, 1, 32'h1C00_0000, 2'b00);
    repeat (5) cyc(0, 0, 0, 2'b00, 1, 0, 0);

    // fill to full with ready low, then drain across the pointer wrap
    cyc(0, 0, 0, 2'b01, 0, $urandom, 2'($urandom));
    repeat (20) cyc(0, 0, 0, 2'b11, 0, $urandom, 2'($urandom));
    repeat (3)  cyc(0, 0, 0, 2'b01, 0, $urandom, 2'($urandom));
    repeat (45) cyc(0, 0, 0, 2'b00, 1, 0, 0);

    // single-lane fill reaches DEPTH-1 on the two-lane instance, then push+pop at the limit
    repeat (36) cyc(0, 0, 0, 2'b01, 0, $urandom, 2'($urandom));
    repeat (20) cyc(0, 0, 0, 2'b11, 1, $urandom, 2'($urandom));
    repeat (45) cyc(0, 0, 0, 2'b00, 1, 0, 0);

    // mixed lane patterns including the non-prefix 2'b10
    repeat (40) cyc(0, 0, 0, 2'($urandom), 1'($urandom), $urandom, 2'($urandom));
    repeat (4)  cyc(0, 0, 0, 2'b10, 1, $urandom, 2'($urandom));

    // stall while the slot holds a request and ready is high
    repeat (2) cyc(0, 0, 0, 2'b01, 0, $urandom, 2'($urandom));
    repeat (3) cyc(0, 1, 0, 2'b11, 1, $urandom, 2'($urandom));
    repeat (12) cyc(0, 0, 0, 2'b00, 1, 0, 0);

    // flush with about ten queued plus a push in the same cycle
    cyc(0, 0, 0, 2'b01, 0, $urandom, 2'($urandom));
    repeat (5) cyc(0, 0, 0, 2'b11, 0, $urandom, 2'($urandom));
    cyc(0, 0, 1, 2'b11, 1, $urandom, 2'($urandom));
    repeat (4) cyc(0, 0, 0, 2'b00, 1, 0, 0);

    // randomized traffic with varying consumer throughput
    for (int b = 0; b < 20; b++) begin
      int pr;
      pr = int'($urandom_range(0, 4));
      repeat (200) cyc(0, ($urandom % 8) == 0, ($urandom % 97) == 0, 2'($urandom),
                       ($urandom % 4) < pr, $urandom, 2'($urandom));
    end

    repeat (100) cyc(0, 0, 0, 2'b00, 1, 0, 0);
    fin_req = 1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
